// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   - hz_state_e : FSM state encodings (RUN=0, LOAD_STALL=1, MEM_WAIT=2; 3 unused)
//   - REG_ZERO   : architectural zero register index (never a real dependency)
//   - src_dep()  : true when an ID source operand depends on the EX destination
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic src_dep(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundle between the pipeline datapath (master) and hazard_ctrl (slave).
//   Pipeline -> controller : id_rs1/id_rs2, id_uses_rs1/id_uses_rs2, ex_rd,
//                            ex_mem_read, ex_redirect, mem_req, mem_ready
//   Controller -> pipeline : stall_if/id/ex/mem, flush_id/ex, mem_timeout, state
//   With HAZARD_PERF_CNT_EN defined: perf_stall_cnt, perf_flush_cnt (controller -> pipeline)
interface hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;

    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_mem;
    logic       flush_id;
    logic       flush_ex;
    logic       mem_timeout;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_redirect, mem_req, mem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, mem_timeout, state
`ifdef HAZARD_PERF_CNT_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_redirect, mem_req, mem_ready,
        output stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, mem_timeout, state
`ifdef HAZARD_PERF_CNT_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer
//   8-bit memory wait counter, saturating at `limit`.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count this cycle
//   limit    : saturation value (1..255)
//   expired  : the count is at the limit after this enabled cycle
module hazard_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count_q;
    logic [7:0] count_nxt;

    always_comb begin
        count_nxt = count_q;
        if (clear) begin
            count_nxt = '0;
        end else if (enable && (count_q < limit)) begin
            count_nxt = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    // Looks at the post-edge value so the flag can latch on the same edge
    // at which the counter reaches the limit.
    assign expired = enable && !clear && (count_nxt == limit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller: memory freeze, EX redirect flush and
//   load-use bubble, with a sticky memory timeout flag.
//   Parameter MAX_WAIT (1..255): MEM_WAIT cycles before mem_timeout sets.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_ctrl_if.slave (pipeline inputs, stall/flush/status outputs)
//   Optional macro HAZARD_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    hz_state_e state_q;
    logic      mem_timeout_q;
    logic      freeze;
    logic      load_use;
    logic      load_use_eff;
    logic      timer_clear;
    logic      timer_en;
    logic      timer_expired;
    logic      stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
    logic      flush_id_c, flush_ex_c;

    assign freeze   = hz.mem_req && !hz.mem_ready;
    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                      (src_dep(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd) ||
                       src_dep(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));
    // The bubble just inserted sits in EX during LOAD_STALL, so a detection
    // there would only be a stale view of the same dependency.
    assign load_use_eff = load_use && (state_q != ST_LOAD_STALL);

    // Hazard controls must act in the cycle the hazard is visible, so they
    // are decoded from the registered state and the live inputs.
    always_comb begin
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_if_c  = 1'b1;
                stall_id_c  = 1'b1;
                stall_ex_c  = 1'b1;
                stall_mem_c = 1'b1;
            end else if (hz.ex_redirect) begin
                flush_id_c = 1'b1;
                flush_ex_c = 1'b1;
            end else if (load_use_eff) begin
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                flush_ex_c = 1'b1;
            end
        end
    end

    assign timer_clear = freeze && (state_q != ST_MEM_WAIT);
    assign timer_en    = (state_q == ST_MEM_WAIT);

    hazard_wait_timer u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (8'(MAX_WAIT)),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            if (timer_en && freeze && timer_expired) begin
                mem_timeout_q <= 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (freeze) begin
                        state_q <= ST_MEM_WAIT;
                    end else if (!hz.ex_redirect && load_use) begin
                        state_q <= ST_LOAD_STALL;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_LOAD_STALL: state_q <= freeze ? ST_MEM_WAIT : ST_RUN;
                ST_MEM_WAIT:   state_q <= freeze ? ST_MEM_WAIT : ST_RUN;
                default:       state_q <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_if_c || stall_id_c || stall_ex_c || stall_mem_c) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_id_c) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`endif

    assign hz.stall_if    = stall_if_c;
    assign hz.stall_id    = stall_id_c;
    assign hz.stall_ex    = stall_ex_c;
    assign hz.stall_mem   = stall_mem_c;
    assign hz.flush_id    = flush_id_c;
    assign hz.flush_ex    = flush_ex_c;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Scoreboard bench for hazard_ctrl. Two instances share the same stimulus:
//   u_dut_a with the default MAX_WAIT and u_dut_b with MAX_WAIT=3.
//   Each directed vector pushes its hand-computed expected outputs; a monitor
//   pops and compares on the falling edge of the same cycle.
//   Perf counters are checked when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    logic clk;
    logic rst;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    hazard_ctrl u_dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (ifa.slave)
    );

    hazard_ctrl #(.MAX_WAIT(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (ifb.slave)
    );

    typedef struct {
        string       name;
        logic [3:0]  stall;   // {if, id, ex, mem}
        logic [1:0]  flush;   // {id, ex}
        logic [1:0]  state;
        logic        to_a;
        logic        to_b;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [1:0] RUN = 2'd0;
    localparam logic [1:0] LS  = 2'd1;
    localparam logic [1:0] MW  = 2'd2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string vec, input string what,
                                input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", vec, what, act, req);
        end
    endfunction

`ifdef HAZARD_PERF_CNT_EN
    int unsigned tally_s = 0;
    int unsigned tally_f = 0;
`endif

    task automatic cyc(input string name, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] uses,
                       input logic [4:0] rd, input logic mr, input logic redir,
                       input logic [1:0] mem,
                       input logic [3:0] e_stall, input logic [1:0] e_flush,
                       input logic [1:0] e_state, input logic [1:0] e_to);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        ifa.id_rs1 = rs1;        ifb.id_rs1 = rs1;
        ifa.id_rs2 = rs2;        ifb.id_rs2 = rs2;
        ifa.id_uses_rs1 = uses[1]; ifb.id_uses_rs1 = uses[1];
        ifa.id_uses_rs2 = uses[0]; ifb.id_uses_rs2 = uses[0];
        ifa.ex_rd = rd;          ifb.ex_rd = rd;
        ifa.ex_mem_read = mr;    ifb.ex_mem_read = mr;
        ifa.ex_redirect = redir; ifb.ex_redirect = redir;
        ifa.mem_req = mem[1];    ifb.mem_req = mem[1];
        ifa.mem_ready = mem[0];  ifb.mem_ready = mem[0];
        e.name  = name;
        e.stall = e_stall;
        e.flush = e_flush;
        e.state = e_state;
        e.to_a  = e_to[1];
        e.to_b  = e_to[0];
        e.ps    = '0;
        e.pf    = '0;
`ifdef HAZARD_PERF_CNT_EN
        if (r) begin
            tally_s = 0;
            tally_f = 0;
        end
        e.ps = tally_s;
        e.pf = tally_f;
        if (!r && (e_stall != 4'b0000)) tally_s++;
        if (!r && e_flush[1]) tally_f++;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle presents a full set of outputs; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall", {28'd0, ifa.stall_if, ifa.stall_id, ifa.stall_ex, ifa.stall_mem}, {28'd0, e.stall});
                chk(e.name, "flush", {30'd0, ifa.flush_id, ifa.flush_ex}, {30'd0, e.flush});
                chk(e.name, "state", {30'd0, ifa.state}, {30'd0, e.state});
                chk(e.name, "timeout_a", {31'd0, ifa.mem_timeout}, {31'd0, e.to_a});
                chk(e.name, "timeout_b", {31'd0, ifb.mem_timeout}, {31'd0, e.to_b});
`ifdef HAZARD_PERF_CNT_EN
                chk(e.name, "perf_stall", ifa.perf_stall_cnt, e.ps);
                chk(e.name, "perf_flush", ifa.perf_flush_cnt, e.pf);
                chk(e.name, "perf_stall_b", ifb.perf_stall_cnt, e.ps);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifa.id_rs1 = '0; ifa.id_rs2 = '0; ifa.id_uses_rs1 = 1'b0; ifa.id_uses_rs2 = 1'b0;
        ifa.ex_rd = '0; ifa.ex_mem_read = 1'b0; ifa.ex_redirect = 1'b0;
        ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
        ifb.id_rs1 = '0; ifb.id_rs2 = '0; ifb.id_uses_rs1 = 1'b0; ifb.id_uses_rs2 = 1'b0;
        ifb.ex_rd = '0; ifb.ex_mem_read = 1'b0; ifb.ex_redirect = 1'b0;
        ifb.mem_req = 1'b0; ifb.mem_ready = 1'b0;

        //   name            rst rs1 rs2 uses  rd mr rd  mem     stall    flush  state to
        cyc("rst_hold",      1, 5, 0, 2'b10, 5, 1, 1, 2'b10, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("rst_idle",      1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("idle",          0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        // load x5 in EX, ID reads x5 via rs1: one bubble
        cyc("lu_rs1",        0, 5, 0, 2'b10, 5, 1, 0, 2'b00, 4'b1100, 2'b01, RUN, 2'b00);
        cyc("lu_masked",     0, 5, 0, 2'b10, 5, 1, 0, 2'b00, 4'b0000, 2'b00, LS,  2'b00);
        cyc("lu_rs1_done",   0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("lu_rs2",        0, 3, 7, 2'b11, 7, 1, 0, 2'b00, 4'b1100, 2'b01, RUN, 2'b00);
        cyc("ls_idle",       0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, LS,  2'b00);
        cyc("ls_idle_done",  0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("no_use",        0, 9, 0, 2'b00, 9, 1, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("not_load",      0, 9, 0, 2'b10, 9, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("x0_load",       0, 0, 0, 2'b11, 0, 1, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        // redirect beats a concurrent load-use
        cyc("redir_lu",      0, 5, 0, 2'b10, 5, 1, 1, 2'b00, 4'b0000, 2'b11, RUN, 2'b00);
        cyc("after_redir",   0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("rst_perf",      1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        // 4 freeze cycles; B (limit 3) times out, A does not
        cyc("frz_entry",     0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, RUN, 2'b00);
        cyc("frz_prio",      0, 5, 0, 2'b10, 5, 1, 1, 2'b10, 4'b1111, 2'b00, MW,  2'b00);
        cyc("frz_w2",        0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, MW,  2'b00);
        cyc("frz_w3",        0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, MW,  2'b00);
        cyc("frz_exit_redir",0, 0, 0, 2'b00, 0, 0, 1, 2'b11, 4'b0000, 2'b11, MW,  2'b01);
        cyc("after_frz",     0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b01);
        cyc("rst_to",        1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        // leave MEM_WAIT through mem_req=0 with a load-use pending
        cyc("frz2",          0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, RUN, 2'b00);
        cyc("frz2_w",        0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, MW,  2'b00);
        cyc("exit_lu",       0, 5, 0, 2'b10, 5, 1, 0, 2'b00, 4'b1100, 2'b01, MW,  2'b00);
        cyc("exit_lu_done",  0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        // freeze arriving during LOAD_STALL
        cyc("lu3",           0, 5, 0, 2'b10, 5, 1, 0, 2'b00, 4'b1100, 2'b01, RUN, 2'b00);
        cyc("ls_frz",        0, 5, 0, 2'b10, 5, 1, 0, 2'b10, 4'b1111, 2'b00, LS,  2'b00);
        cyc("ls_frz_w",      0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, MW,  2'b00);
        cyc("ls_frz_exit",   0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 4'b0000, 2'b00, MW,  2'b00);
        cyc("ls_frz_done",   0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        // reset mid-MEM_WAIT and mid-LOAD_STALL
        cyc("frz3",          0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, RUN, 2'b00);
        cyc("frz3_w",        0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 4'b1111, 2'b00, MW,  2'b00);
        cyc("rst_mw",        1, 5, 0, 2'b10, 5, 1, 0, 2'b10, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("post_rst_mw",   0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("lu4",           0, 5, 0, 2'b10, 5, 1, 0, 2'b00, 4'b1100, 2'b01, RUN, 2'b00);
        cyc("rst_ls",        1, 5, 0, 2'b10, 5, 1, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);
        cyc("post_rst_ls",   0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 4'b0000, 2'b00, RUN, 2'b00);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory wait-cycle limit before mem_timeout sets; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads that source.
REQ-006 ex_rd  input  5  destination register of the instruction in EX.
REQ-007 ex_mem_read  input  1  EX instruction is a load.
REQ-008 ex_redirect  input  1  taken branch, JAL or JALR resolved in EX.
REQ-009 mem_req  input  1  MEM stage has an active data-memory access.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold that pipeline register.
REQ-012 flush_id, flush_ex  output  1 each  replace that stage's contents with a NOP (all controls deasserted).
REQ-013 mem_timeout  output  1  sticky error flag.
REQ-014 state  output  2  current FSM state for debug.

Function
REQ-015 freeze = mem_req & ~mem_ready; while freeze=1, all four stall outputs SHALL be 1 and both flush outputs 0, in any state.
REQ-016 load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-017 Priority, highest first: freeze, ex_redirect, load_use.
REQ-018 With no freeze, ex_redirect SHALL assert flush_id=1 and flush_ex=1 for that cycle, with all stalls 0; a concurrent load_use is discarded.
REQ-019 With no freeze and no redirect, load_use SHALL assert stall_if=1, stall_id=1 and flush_ex=1 for exactly one cycle (one bubble).
REQ-020 An ex_redirect masked by freeze SHALL take effect on the first cycle freeze is 0 (EX is held, so the input persists); no internal latch.
REQ-021 FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2; encoding 3 unreachable and SHALL recover to RUN.
REQ-022 RUN -> MEM_WAIT when freeze; RUN -> LOAD_STALL when load_use and no freeze and no redirect; otherwise stay in RUN.
REQ-023 LOAD_STALL: load_use detection is masked; -> MEM_WAIT when freeze, else -> RUN after one cycle.
REQ-024 MEM_WAIT -> RUN on the cycle mem_ready=1 or mem_req=0; the hazard outputs for that cycle are evaluated per REQ-018/019.
REQ-025 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each cycle in MEM_WAIT, saturating at MAX_WAIT.
REQ-026 When the counter reaches MAX_WAIT with mem_ready=0, mem_timeout SHALL set and hold until reset; the freeze continues.
REQ-027 ex_rd == 0 SHALL never cause a stall.

Reset
REQ-028 While rst=1: state=RUN, counter=0, mem_timeout=0, all stall and flush outputs 0 regardless of inputs.
REQ-029 Reset asserted mid-MEM_WAIT or mid-LOAD_STALL SHALL abort the state with no pending action on release.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (cycles with any stall=1) and perf_flush_cnt[31:0] (cycles with flush_id=1); both wrap modulo 2^32 and reset to 0.
REQ-031 Macro absent: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 The shared package SHALL hold the FSM state encodings and the REG_ZERO constant; opcode constants stay with the decoder.
REQ-033 The wait counter and timeout compare SHALL be sub-module hazard_wait_timer (inputs clear, enable, limit; output expired).

Verification
REQ-034 Load x5 in EX, ID uses rs1=x5 -> one cycle of stall_if=1, stall_id=1, flush_ex=1, state=LOAD_STALL, then RUN with no stall.
REQ-035 Load with ex_rd=0 and id_rs1=0 -> no stall and no flush.
REQ-036 ex_redirect=1 together with load_use=1 -> flush_id=1, flush_ex=1, all stalls 0, state stays RUN.
REQ-037 mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all stalls 1 for 4 cycles, state=MEM_WAIT, RUN on the 5th cycle, mem_timeout=0.
REQ-038 MAX_WAIT=3, mem_ready held at 0 -> mem_timeout=1 after 3 MEM_WAIT cycles, still 1 after mem_ready; rst clears it.
REQ-039 rst pulsed mid-MEM_WAIT, and under HAZARD_PERF_CNT_EN after 2 stalls and 1 flush -> outputs 0, state=RUN; perf_stall_cnt=2 and perf_flush_cnt=1 before the reset, both 0 after.
